// File: rtl/posit_add_align_pipe_if.sv
// Operand/result handshake bundle for the posit add align/add/normalise core.
// master drives operands and consumes results; slave is the core.
interface posit_add_align_pipe_if #(
  parameter int N  = 8,
  parameter int ES = 3,
  parameter int RS = $clog2(N)
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 A_Sign;
  logic                 B_Sign;
  logic signed [RS:0]   A_k;
  logic signed [RS:0]   B_k;
  logic [ES-1:0]        A_Exponent;
  logic [ES-1:0]        B_Exponent;
  logic [N-1:0]         A_Mantissa;
  logic [N-1:0]         B_Mantissa;
  logic                 A_inf;
  logic                 B_inf;
  logic                 A_zero;
  logic                 B_zero;

  logic                 out_valid;
  logic                 out_ready;
  logic                 Sign;
  logic signed [RS:0]   k;
  logic [ES-1:0]        Exponent;
  logic [N-1:0]         Mantissa;
  logic                 inf;
  logic                 zero;

  modport master (
    output in_valid, A_Sign, B_Sign, A_k, B_k, A_Exponent, B_Exponent,
           A_Mantissa, B_Mantissa, A_inf, B_inf, A_zero, B_zero, out_ready,
    input  in_ready, out_valid, Sign, k, Exponent, Mantissa, inf, zero
  );

  modport slave (
    input  in_valid, A_Sign, B_Sign, A_k, B_k, A_Exponent, B_Exponent,
           A_Mantissa, B_Mantissa, A_inf, B_inf, A_zero, B_zero, out_ready,
    output in_ready, out_valid, Sign, k, Exponent, Mantissa, inf, zero
  );
endinterface

// File: rtl/posit_add_align_pipe.sv
// Three-stage posit add core: compare/swap, align/add, normalise/clamp.
// One global advance signal moves every stage together; outputs are the stage-3 registers.
module posit_add_align_pipe #(
  parameter int N  = 8,
  parameter int ES = 3,
  parameter int RS = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  posit_add_align_pipe_if.slave io
);

  localparam int W   = RS + ES + 3;       // signed scale width
  localparam int SW  = 2 * N;             // aligned mantissa width
  localparam int LZW = $clog2(SW + 1);
  localparam logic signed [W-1:0] K_MAX = W'(N - 2);
  localparam logic signed [W-1:0] K_MIN = -K_MAX;

  logic adv;
  assign adv = ~io.out_valid | io.out_ready;
  assign io.in_ready = adv;

  // ---------------- stage 1: compare / swap ----------------
  logic signed [W-1:0] a_scale, b_scale;
  logic [N-1:0]        a_mant, b_mant;
  logic                a_is_l;

  logic                s1_valid_d, s1_valid_q;
  logic                s1_sl_d, s1_sl_q;
  logic                s1_eff_sub_d, s1_eff_sub_q;
  logic signed [W-1:0] s1_el_d, s1_el_q;
  logic [W-1:0]        s1_d_d, s1_d_q;
  logic [N-1:0]        s1_ml_d, s1_ml_q;
  logic [N-1:0]        s1_ms_d, s1_ms_q;
  logic                s1_inf_d, s1_inf_q;
  logic                s1_both_zero_d, s1_both_zero_q;
  logic                s1_one_zero_d, s1_one_zero_q;

  assign a_scale = (W'(io.A_k) <<< ES) + W'(io.A_Exponent);
  assign b_scale = (W'(io.B_k) <<< ES) + W'(io.B_Exponent);
  assign a_mant  = io.A_zero ? '0 : io.A_Mantissa;
  assign b_mant  = io.B_zero ? '0 : io.B_Mantissa;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    a_is_l = 1'b1;
    // With exactly one zero operand the live one becomes L, so its fields reach stage 3 intact.
    if (io.A_zero != io.B_zero)  a_is_l = io.B_zero;
    else if (a_scale != b_scale) a_is_l = (a_scale > b_scale);
    else                         a_is_l = (a_mant >= b_mant);
  end

  always_comb begin
    s1_valid_d     = io.in_valid;
    s1_sl_d        = a_is_l ? io.A_Sign : io.B_Sign;
    s1_eff_sub_d   = io.A_Sign ^ io.B_Sign;
    s1_el_d        = a_is_l ? a_scale : b_scale;
    s1_d_d         = a_is_l ? W'(a_scale - b_scale) : W'(b_scale - a_scale);
    s1_ml_d        = a_is_l ? a_mant : b_mant;
    s1_ms_d        = a_is_l ? b_mant : a_mant;
    s1_inf_d       = io.A_inf | io.B_inf;
    s1_both_zero_d = io.A_zero & io.B_zero;
    s1_one_zero_d  = io.A_zero ^ io.B_zero;
  end

  // ---------------- stage 2: align / add ----------------
  logic [SW-1:0]       ms_aligned;
  logic                s2_valid_q;
  logic                s2_sl_q;
  logic signed [W-1:0] s2_el_q;
  logic [N-1:0]        s2_ml_q;
  logic [SW:0]         s2_sum_d, s2_sum_q;
  logic                s2_inf_q;
  logic                s2_both_zero_q;
  logic                s2_one_zero_q;

  // Bits shifted past the bottom are dropped; there is no sticky bit.
  assign ms_aligned = (s1_d_q >= W'(SW)) ? '0 : ({s1_ms_q, {N{1'b0}}} >> s1_d_q);

  always_comb begin
    if (s1_eff_sub_q) s2_sum_d = {1'b0, s1_ml_q, {N{1'b0}}} - {1'b0, ms_aligned};
    else              s2_sum_d = {1'b0, s1_ml_q, {N{1'b0}}} + {1'b0, ms_aligned};
  end

  // ---------------- stage 3: normalise / clamp / specials ----------------
  logic [LZW-1:0]      lz;
  logic                carry;
  logic signed [W-1:0] e_norm;
  logic signed [W-1:0] k_wide;
  logic [N-1:0]        norm_mant;

  logic                s3_valid_q;
  logic                s3_sign_d, s3_sign_q;
  logic signed [RS:0]  s3_k_d, s3_k_q;
  logic [ES-1:0]       s3_exp_d, s3_exp_q;
  logic [N-1:0]        s3_mant_d, s3_mant_q;
  logic                s3_inf_d, s3_inf_q;
  logic                s3_zero_d, s3_zero_q;

  always_comb begin
    lz = LZW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (s2_sum_q[i]) lz = LZW'(SW - 1 - i);
    end
  end

  assign carry     = s2_sum_q[SW];
  assign e_norm    = carry ? s2_el_q + W'(1) : s2_el_q - W'(lz);
  assign k_wide    = e_norm >>> ES;
  assign norm_mant = carry ? s2_sum_q[SW:N+1] : N'((s2_sum_q[SW-1:0] << lz) >> N);

  always_comb begin
    s3_sign_d = s2_sl_q;
    s3_k_d    = (RS+1)'(k_wide);
    s3_exp_d  = e_norm[ES-1:0];
    s3_mant_d = norm_mant;
    s3_inf_d  = 1'b0;
    s3_zero_d = 1'b0;
    if (s2_inf_q) begin
      s3_sign_d = 1'b1;
      s3_k_d    = '0;
      s3_exp_d  = '0;
      s3_mant_d = '0;
      s3_inf_d  = 1'b1;
    end else if (s2_both_zero_q || (s2_sum_q == '0)) begin
      s3_sign_d = 1'b0;
      s3_k_d    = '0;
      s3_exp_d  = '0;
      s3_mant_d = '0;
      s3_zero_d = 1'b1;
    end else if (s2_one_zero_q) begin
      // The live operand is L, so its scale splits back into its own k and exponent.
      s3_k_d    = (RS+1)'(s2_el_q >>> ES);
      s3_exp_d  = s2_el_q[ES-1:0];
      s3_mant_d = s2_ml_q;
    end else if (k_wide > K_MAX) begin
      s3_k_d    = (RS+1)'(K_MAX);
      s3_exp_d  = '0;
      s3_mant_d = N'(1) << (N - 1);
    end else if (k_wide < K_MIN) begin
      s3_k_d    = (RS+1)'(K_MIN);
      s3_exp_d  = '0;
      s3_mant_d = N'(1) << (N - 1);
    end
  end

  // ---------------- pipeline registers ----------------
  // NOTE: data registers are reset too, so outputs read all-zero during and right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q     <= 1'b0;
      s1_sl_q        <= 1'b0;
      s1_eff_sub_q   <= 1'b0;
      s1_el_q        <= '0;
      s1_d_q         <= '0;
      s1_ml_q        <= '0;
      s1_ms_q        <= '0;
      s1_inf_q       <= 1'b0;
      s1_both_zero_q <= 1'b0;
      s1_one_zero_q  <= 1'b0;
      s2_valid_q     <= 1'b0;
      s2_sl_q        <= 1'b0;
      s2_el_q        <= '0;
      s2_ml_q        <= '0;
      s2_sum_q       <= '0;
      s2_inf_q       <= 1'b0;
      s2_both_zero_q <= 1'b0;
      s2_one_zero_q  <= 1'b0;
      s3_valid_q     <= 1'b0;
      s3_sign_q      <= 1'b0;
      s3_k_q         <= '0;
      s3_exp_q       <= '0;
      s3_mant_q      <= '0;
      s3_inf_q       <= 1'b0;
      s3_zero_q      <= 1'b0;
    end else if (adv) begin
      // NOTE: non-blocking assignments let all three stages shift on the same edge.
      s1_valid_q     <= s1_valid_d;
      s1_sl_q        <= s1_sl_d;
      s1_eff_sub_q   <= s1_eff_sub_d;
      s1_el_q        <= s1_el_d;
      s1_d_q         <= s1_d_d;
      s1_ml_q        <= s1_ml_d;
      s1_ms_q        <= s1_ms_d;
      s1_inf_q       <= s1_inf_d;
      s1_both_zero_q <= s1_both_zero_d;
      s1_one_zero_q  <= s1_one_zero_d;
      s2_valid_q     <= s1_valid_q;
      s2_sl_q        <= s1_sl_q;
      s2_el_q        <= s1_el_q;
      s2_ml_q        <= s1_ml_q;
      s2_sum_q       <= s2_sum_d;
      s2_inf_q       <= s1_inf_q;
      s2_both_zero_q <= s1_both_zero_q;
      s2_one_zero_q  <= s1_one_zero_q;
      s3_valid_q     <= s2_valid_q;
      s3_sign_q      <= s3_sign_d;
      s3_k_q         <= s3_k_d;
      s3_exp_q       <= s3_exp_d;
      s3_mant_q      <= s3_mant_d;
      s3_inf_q       <= s3_inf_d;
      s3_zero_q      <= s3_zero_d;
    end
  end

  assign io.out_valid = s3_valid_q;
  assign io.Sign      = s3_sign_q;
  assign io.k         = s3_k_q;
  assign io.Exponent  = s3_exp_q;
  assign io.Mantissa  = s3_mant_q;
  assign io.inf       = s3_inf_q;
  assign io.zero      = s3_zero_q;

endmodule

// File: tb/tb_posit_add_align_pipe.sv
// Scoreboard bench for posit_add_align_pipe: directed operand pairs with hand-computed
// results, a back-pressure stream, and an asynchronous reset with operations in flight.
module tb_posit_add_align_pipe;
  localparam int N  = 8;
  localparam int ES = 3;
  localparam int RS = $clog2(N);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  posit_add_align_pipe_if #(.N(N), .ES(ES), .RS(RS)) bus ();
  posit_add_align_pipe #(.N(N), .ES(ES), .RS(RS)) dut (.clk(clk), .rst_n(rst_n), .io(bus));

  typedef struct packed {
    logic       sign;
    logic [3:0] k;
    logic [2:0] e;
    logic [7:0] m;
    logic       inf;
    logic       zero;
  } fld_t;

  typedef struct {
    string name;
    fld_t  a;
    fld_t  b;
    fld_t  r;
  } vec_t;

  typedef struct {
    string name;
    fld_t  r;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  vec_t vecs[$];

  function automatic fld_t f(input logic s, input int kk, input int ee, input int mm,
                             input logic is_inf = 1'b0, input logic is_zero = 1'b0);
    fld_t x;
    x.sign = s;
    x.k    = 4'(kk);
    x.e    = 3'(ee);
    x.m    = 8'(mm);
    x.inf  = is_inf;
    x.zero = is_zero;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  function automatic fld_t dut_out();
    fld_t x;
    x.sign = bus.Sign;
    x.k    = bus.k;
    x.e    = bus.Exponent;
    x.m    = bus.Mantissa;
    x.inf  = bus.inf;
    x.zero = bus.zero;
    return x;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input vec_t v);
    int n;
    bus.A_Sign = v.a.sign; bus.A_k = v.a.k; bus.A_Exponent = v.a.e; bus.A_Mantissa = v.a.m;
    bus.A_inf  = v.a.inf;  bus.A_zero = v.a.zero;
    bus.B_Sign = v.b.sign; bus.B_k = v.b.k; bus.B_Exponent = v.b.e; bus.B_Mantissa = v.b.m;
    bus.B_inf  = v.b.inf;  bus.B_zero = v.b.zero;
    bus.in_valid = 1'b1;
    n = 0;
    #2;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk);
      #3;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_%s: in_ready stayed 0 for %0d cycles, expected 1", v.name, n);
    end
    exp_q.push_back('{name: v.name, r: v.r});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #6;
    check({"drain_", name}, exp_q.size(), 0);
  endtask

  // Monitor: compares every transfer against the scoreboard and checks stall stability.
  logic stalled_prev = 1'b0;
  fld_t prev_out;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled_prev = 1'b0;
      end else begin
        if (stalled_prev) begin
          check("hold_fields", dut_out(), prev_out);
          check("hold_valid", bus.out_valid, 1);
        end
        if (bus.out_valid) check("in_ready_follows", bus.in_ready, bus.out_ready);
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h, expected no result", dut_out());
          end else begin
            e = exp_q.pop_front();
            check(e.name, dut_out(), e.r);
          end
        end
        stalled_prev = bus.out_valid && !bus.out_ready;
        prev_out     = dut_out();
      end
    end
  end

  initial begin
    fld_t one, two, m_one, three, m_two, zero_r, inf_r;
    one    = f(0, 0, 0, 'h80);
    two    = f(0, 0, 1, 'h80);
    m_one  = f(1, 0, 0, 'h80);
    three  = f(0, 0, 1, 'hC0);
    m_two  = f(1, 0, 1, 'h80);
    zero_r = f(0, 0, 0, 0, 0, 1);
    inf_r  = f(1, 0, 0, 0, 1, 0);

    vecs.push_back('{"one_plus_one",   one, one,   f(0, 0, 1, 'h80)});   // 0
    vecs.push_back('{"one_plus_two",   one, two,   f(0, 0, 1, 'hC0)});   // 1
    vecs.push_back('{"two_plus_one",   two, one,   f(0, 0, 1, 'hC0)});   // 2
    vecs.push_back('{"one_minus_one",  one, m_one, zero_r});             // 3
    vecs.push_back('{"a_inf",          f(0, 2, 3, 'h90, 1, 0), three, inf_r});
    vecs.push_back('{"three_minus_two", three, m_two, f(0, 0, 0, 'h80)}); // 5
    vecs.push_back('{"azero_plus_three", f(0, 5, 2, 'h80, 0, 1), three, f(0, 0, 1, 'hC0)});
    vecs.push_back('{"three_plus_bzero", three, f(1, -3, 4, 'hA0, 0, 1), f(0, 0, 1, 'hC0)});
    vecs.push_back('{"both_zero", f(0, 1, 1, 'h80, 0, 1), f(1, 2, 2, 'h80, 0, 1), zero_r});
    vecs.push_back('{"clamp_high", f(0, 6, 7, 'h80), f(0, 6, 7, 'h80), f(0, 6, 0, 'h80)}); // 9
    vecs.push_back('{"clamp_low", f(0, -6, 0, 'h80), f(1, -6, 0, 'hC0), f(1, -6, 0, 'h80)});
    vecs.push_back('{"shift_15", f(0, 1, 7, 'h80), f(1, 0, 0, 'hFF), f(0, 1, 6, 'hFF)});
    vecs.push_back('{"shift_16", f(0, 2, 0, 'h80), f(1, 0, 0, 'hFF), f(0, 2, 0, 'h80)});
    vecs.push_back('{"shift_24", f(0, 3, 0, 'h80), f(0, 0, 0, 'h80), f(0, 3, 0, 'h80)});
    vecs.push_back('{"lz_two", f(0, 1, 0, 'h80), f(1, 0, 7, 'hC0), f(0, 0, 6, 'h80)}); // 14
    vecs.push_back('{"neg_k_carry", f(0, -1, 5, 'hA0), f(0, -1, 5, 'hA0), f(0, -1, 6, 'hA0)});
    vecs.push_back('{"azero_binf", f(0, 0, 0, 0, 0, 1), f(0, 0, 0, 0, 1, 0), inf_r});
    vecs.push_back('{"mtwo_plus_three", m_two, three, f(0, 0, 0, 'h80)});
    vecs.push_back('{"mone_plus_mone", m_one, m_one, f(1, 0, 1, 'h80)}); // 18

    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.A_Sign = 0; bus.A_k = '0; bus.A_Exponent = '0; bus.A_Mantissa = '0;
    bus.A_inf = 0; bus.A_zero = 0;
    bus.B_Sign = 0; bus.B_k = '0; bus.B_Exponent = '0; bus.B_Mantissa = '0;
    bus.B_inf = 0; bus.B_zero = 0;

    #1 rst_n = 1'b0;
    #2;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_fields", dut_out(), '0);
    check("reset_in_ready", bus.in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: result valid after the third edge counting the accepting edge.
    send(vecs[0]);
    @(posedge clk); #1;
    check("latency_edge2", bus.out_valid, 0);
    @(posedge clk); #1;
    check("latency_edge3", bus.out_valid, 1);
    drain("latency");

    @(posedge clk); #1;
    foreach (vecs[i]) send(vecs[i]);
    drain("directed");

    // Back-to-back stream with out_ready low for four cycles.
    @(posedge clk); #1;
    fork
      begin
        send(vecs[0]); send(vecs[1]); send(vecs[5]);
        send(vecs[9]); send(vecs[14]); send(vecs[18]);
      end
      begin
        repeat (3) @(posedge clk);
        #2 bus.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #2 bus.out_ready = 1'b1;
      end
    join
    drain("stream");

    // Asynchronous reset with operations in flight.
    @(posedge clk); #1;
    send(vecs[1]); send(vecs[2]); send(vecs[3]);
    check("pre_reset_valid", bus.out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_valid", bus.out_valid, 0);
    check("async_reset_fields", dut_out(), '0);
    check("async_reset_in_ready", bus.in_ready, 1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(vecs[15]);
    @(posedge clk); #1;
    check("post_reset_edge2", bus.out_valid, 0);
    @(posedge clk); #1;
    check("post_reset_edge3", bus.out_valid, 1);
    drain("post_reset");
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
